// File: rtl/char_window_mover.sv
// Window position of one magnified character cell inside the active display, stepped by
// synchronised Left/Right/Up/Down requests with auto-repeat, wrap-around and recentring.
module char_window_mover #(
    parameter int unsigned H_DISP   = 640,
    parameter int unsigned V_DISP   = 400,
    parameter int unsigned CHAR_W   = 8,
    parameter int unsigned CHAR_H   = 16,
    parameter int unsigned COORD_W  = 10,
    parameter int unsigned MAG_W    = 3,
    parameter int unsigned REP_DLY  = 25000000,
    parameter int unsigned REP_RATE = 6250000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         move_req,
    input  logic               recenter,
    input  logic [MAG_W-1:0]   mag,
    output logic [COORD_W-1:0] hor_start,
    output logic [COORD_W-1:0] hor_end,
    output logic [COORD_W-1:0] ver_start,
    output logic [COORD_W-1:0] ver_end,
    output logic               moved,
    output logic               wrap_h,
    output logic               wrap_v
);

    localparam int unsigned AW      = COORD_W + 1;
    localparam int unsigned CNT_MAX = (REP_DLY > REP_RATE) ? REP_DLY : REP_RATE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [AW-1:0] H_A = AW'(H_DISP);
    localparam logic [AW-1:0] V_A = AW'(V_DISP);

    localparam logic [COORD_W-1:0] HS0 = COORD_W'((H_DISP - CHAR_W) / 2);
    localparam logic [COORD_W-1:0] HE0 = COORD_W'((H_DISP - CHAR_W) / 2 + CHAR_W - 1);
    localparam logic [COORD_W-1:0] VS0 = COORD_W'((V_DISP - CHAR_H) / 2);
    localparam logic [COORD_W-1:0] VE0 = COORD_W'((V_DISP - CHAR_H) / 2 + CHAR_H - 1);

    logic [MAG_W-1:0]   r_mag_q, r_mag_prev, w_mag_n;
    logic [3:0]         r_sync1, r_sync2, r_prev;
    logic [3:0]         w_rise, w_ev;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_rep_phase;
    logic               w_changed, w_held, w_fire;
    logic [COORD_W-1:0] r_hs, r_he, r_vs, r_ve;
    logic               r_moved, r_wrap_h, r_wrap_v;
    logic [AW-1:0]      w_w, w_h, w_hc, w_vc, w_hs, w_vs;
    logic [AW-1:0]      w_hs_n, w_vs_n, w_he_n, w_ve_n;
    logic               w_recentre, w_hmove, w_vmove, w_hwrap, w_vwrap;

    assign w_mag_n    = (mag == '0) ? MAG_W'(1) : mag;
    assign w_w        = AW'(CHAR_W) * AW'(r_mag_q);
    assign w_h        = AW'(CHAR_H) * AW'(r_mag_q);
    assign w_hc       = (H_A - w_w) >> 1;
    assign w_vc       = (V_A - w_h) >> 1;
    assign w_hs       = AW'(r_hs);
    assign w_vs       = AW'(r_vs);
    assign w_recentre = recenter || (r_mag_q != r_mag_prev);

    assign w_changed = (r_sync2 != r_prev);
    assign w_held    = |r_sync2;
    assign w_fire    = (REP_DLY != 0) && w_held && !w_changed &&
                       (r_rep_phase ? (r_cnt == CNT_W'(REP_RATE)) : (r_cnt == CNT_W'(REP_DLY)));
    assign w_rise    = r_sync2 & ~r_prev;
    // A repeat strobe behaves as a fresh rise on every bit still held.
    assign w_ev      = w_rise | ({4{w_fire}} & r_sync2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= move_req;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Counter value equals cycles elapsed since the last vector change (or last repeat).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_rep_phase <= 1'b0;
        end else if (w_changed) begin
            r_cnt       <= CNT_W'(1);
            r_rep_phase <= 1'b0;
        end else if (!w_held || (REP_DLY == 0)) begin
            r_cnt       <= '0;
            r_rep_phase <= 1'b0;
        end else if (w_fire) begin
            r_cnt       <= CNT_W'(1);
            r_rep_phase <= 1'b1;
        end else begin
            r_cnt       <= r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_hs_n  = w_hs;
        w_vs_n  = w_vs;
        w_hmove = 1'b0;
        w_vmove = 1'b0;
        w_hwrap = 1'b0;
        w_vwrap = 1'b0;
        if (w_recentre) begin
            w_hs_n = w_hc;
            w_vs_n = w_vc;
        end else begin
            if (w_ev[3] ^ w_ev[2]) begin
                w_hmove = 1'b1;
                if (w_ev[3]) begin
                    if (w_hs >= w_w) begin
                        w_hs_n = w_hs - w_w;
                    end else begin
                        w_hs_n  = H_A - w_w;
                        w_hwrap = 1'b1;
                    end
                end else if (w_hs + (w_w << 1) <= H_A) begin
                    w_hs_n = w_hs + w_w;
                end else begin
                    w_hs_n  = '0;
                    w_hwrap = 1'b1;
                end
            end
            if (w_ev[1] ^ w_ev[0]) begin
                w_vmove = 1'b1;
                if (w_ev[1]) begin
                    if (w_vs >= w_h) begin
                        w_vs_n = w_vs - w_h;
                    end else begin
                        w_vs_n  = V_A - w_h;
                        w_vwrap = 1'b1;
                    end
                end else if (w_vs + (w_h << 1) <= V_A) begin
                    w_vs_n = w_vs + w_h;
                end else begin
                    w_vs_n  = '0;
                    w_vwrap = 1'b1;
                end
            end
        end
    end

    assign w_he_n = w_hs_n + w_w - AW'(1);
    assign w_ve_n = w_vs_n + w_h - AW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mag_q    <= MAG_W'(1);
            r_mag_prev <= MAG_W'(1);
            r_hs       <= HS0;
            r_he       <= HE0;
            r_vs       <= VS0;
            r_ve       <= VE0;
            r_moved    <= 1'b0;
            r_wrap_h   <= 1'b0;
            r_wrap_v   <= 1'b0;
        end else begin
            r_mag_q    <= w_mag_n;
            r_mag_prev <= r_mag_q;
            r_hs       <= COORD_W'(w_hs_n);
            r_he       <= COORD_W'(w_he_n);
            r_vs       <= COORD_W'(w_vs_n);
            r_ve       <= COORD_W'(w_ve_n);
            r_moved    <= w_hmove | w_vmove;
            r_wrap_h   <= w_hwrap;
            r_wrap_v   <= w_vwrap;
        end
    end

    assign hor_start = r_hs;
    assign hor_end   = r_he;
    assign ver_start = r_vs;
    assign ver_end   = r_ve;
    assign moved     = r_moved;
    assign wrap_h    = r_wrap_h;
    assign wrap_v    = r_wrap_v;

endmodule

// File: tb/tb_char_window_mover.sv
// Bench for char_window_mover: directed vector table, corner sequences and a randomised
// run, all cross-checked every cycle against an arithmetic reference model.
module tb_char_window_mover;

    localparam int H  = 640;
    localparam int V  = 400;
    localparam int CW = 8;
    localparam int CH = 16;
    localparam int RD = 4;
    localparam int RR = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       recenter = 1'b0;
    logic [3:0] move_req = 4'b0;
    logic [2:0] mag = 3'd1;
    logic [9:0] hor_start, hor_end, ver_start, ver_end;
    logic       moved, wrap_h, wrap_v;

    always #5 clk = ~clk;

    char_window_mover #(
        .H_DISP(H), .V_DISP(V), .CHAR_W(CW), .CHAR_H(CH),
        .COORD_W(10), .MAG_W(3), .REP_DLY(RD), .REP_RATE(RR)
    ) dut (
        .clk(clk), .reset(reset), .move_req(move_req), .recenter(recenter), .mag(mag),
        .hor_start(hor_start), .hor_end(hor_end), .ver_start(ver_start), .ver_end(ver_end),
        .moved(moved), .wrap_h(wrap_h), .wrap_v(wrap_v)
    );

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // ---------------- reference model ----------------
    typedef struct {
        int hs, he, vs, ve, k;
        bit mv, wh, wv;
    } nxt_t;

    // Input history: samples taken at the last three edges; the DUT acts on the one two edges old.
    logic [3:0] smp1, smp2, smp3;
    int k_reg, mq, mprev, e_hs, e_he, e_vs, e_ve;
    bit e_mv, e_wh, e_wv;

    function automatic nxt_t step(input logic [3:0] cur, input logic [3:0] prv, input int k_prev,
                                  input int m, input int m_old, input int hs_i, input int vs_i,
                                  input bit rc);
        nxt_t n;
        int w, h, k;
        bit fire;
        logic [3:0] ev;
        w = CW * m;
        h = CH * m;
        k = (cur != prv) ? 0 : k_prev + 1;
        fire = (cur != 4'b0) && (RD != 0) && (k >= RD) && (((k - RD) % RR) == 0);
        ev = (cur & ~prv) | (fire ? cur : 4'b0);
        n.hs = hs_i; n.vs = vs_i; n.k = k;
        n.mv = 0; n.wh = 0; n.wv = 0;
        if (rc || (m != m_old)) begin
            n.hs = (H - w) / 2;
            n.vs = (V - h) / 2;
        end else begin
            if (ev[3] != ev[2]) begin
                n.mv = 1;
                if (ev[3]) begin
                    if (hs_i >= w) n.hs = hs_i - w;
                    else begin n.hs = H - w; n.wh = 1; end
                end else begin
                    if (hs_i + 2 * w <= H) n.hs = hs_i + w;
                    else begin n.hs = 0; n.wh = 1; end
                end
            end
            if (ev[1] != ev[0]) begin
                n.mv = 1;
                if (ev[1]) begin
                    if (vs_i >= h) n.vs = vs_i - h;
                    else begin n.vs = V - h; n.wv = 1; end
                end else begin
                    if (vs_i + 2 * h <= V) n.vs = vs_i + h;
                    else begin n.vs = 0; n.wv = 1; end
                end
            end
        end
        n.he = n.hs + w - 1;
        n.ve = n.vs + h - 1;
        return n;
    endfunction

    nxt_t nx;
    assign nx = step(smp2, smp3, k_reg, mq, mprev, e_hs, e_vs, recenter);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            smp1 <= 4'b0; smp2 <= 4'b0; smp3 <= 4'b0;
            k_reg <= 0; mq <= 1; mprev <= 1;
            e_hs <= (H - CW) / 2; e_he <= (H - CW) / 2 + CW - 1;
            e_vs <= (V - CH) / 2; e_ve <= (V - CH) / 2 + CH - 1;
            e_mv <= 0; e_wh <= 0; e_wv <= 0;
        end else begin
            smp1 <= move_req; smp2 <= smp1; smp3 <= smp2;
            k_reg <= nx.k; mprev <= mq; mq <= (mag == 3'd0) ? 1 : int'(mag);
            e_hs <= nx.hs; e_he <= nx.he; e_vs <= nx.vs; e_ve <= nx.ve;
            e_mv <= nx.mv; e_wh <= nx.wh; e_wv <= nx.wv;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({hor_start, hor_end, ver_start, ver_end, moved, wrap_h, wrap_v} !==
                {10'(e_hs), 10'(e_he), 10'(e_vs), 10'(e_ve), e_mv, e_wh, e_wv}) begin
                failures++;
                $display("FAIL model t=%0t got h=%0d/%0d v=%0d/%0d mv=%b wh=%b wv=%b expected h=%0d/%0d v=%0d/%0d mv=%b wh=%b wv=%b",
                         $time, hor_start, hor_end, ver_start, ver_end, moved, wrap_h, wrap_v,
                         e_hs, e_he, e_vs, e_ve, e_mv, e_wh, e_wv);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic pulse(input logic [3:0] mv, input bit rc, input logic [2:0] mg, input int hold,
                         output int nm, output bit wh, output bit wv);
        @(negedge clk);
        move_req = mv; recenter = rc; mag = mg;
        nm = 0; wh = 0; wv = 0;
        for (int i = 0; i < hold + 6; i++) begin
            @(negedge clk);
            if (moved) nm++;
            wh |= wrap_h;
            wv |= wrap_v;
            if (i == hold - 1) begin
                move_req = 4'b0;
                recenter = 1'b0;
            end
        end
    endtask

    typedef struct {
        logic [3:0] mv;
        bit         rc;
        logic [2:0] mg;
        int         hold;
        int         hs, he, vs, ve, nmv;
        bit         wh, wv;
    } vec_t;

    vec_t tbl[13];
    int   offs[$];
    int   exp_off[5] = '{0, 4, 6, 8, 10};
    int   nm;
    bit   wh, wv;

    initial begin
        tbl[0]  = '{4'b0100, 0, 3'd1, 4, 324, 331, 192, 207, 1, 0, 0};
        tbl[1]  = '{4'b0000, 1, 3'd1, 1, 316, 323, 192, 207, 0, 0, 0};
        tbl[2]  = '{4'b1000, 0, 3'd1, 2, 308, 315, 192, 207, 1, 0, 0};
        tbl[3]  = '{4'b0001, 0, 3'd1, 2, 308, 315, 208, 223, 1, 0, 0};
        tbl[4]  = '{4'b1100, 0, 3'd1, 2, 308, 315, 208, 223, 0, 0, 0};
        tbl[5]  = '{4'b1001, 0, 3'd1, 2, 300, 307, 224, 239, 1, 0, 0};
        tbl[6]  = '{4'b0011, 0, 3'd1, 2, 300, 307, 224, 239, 0, 0, 0};
        tbl[7]  = '{4'b0000, 1, 3'd1, 1, 316, 323, 192, 207, 0, 0, 0};
        tbl[8]  = '{4'b0100, 0, 3'd1, 2, 324, 331, 192, 207, 1, 0, 0};
        tbl[9]  = '{4'b0000, 0, 3'd2, 1, 312, 327, 184, 215, 0, 0, 0};
        tbl[10] = '{4'b0100, 0, 3'd2, 2, 328, 343, 184, 215, 1, 0, 0};
        tbl[11] = '{4'b0000, 0, 3'd0, 1, 316, 323, 192, 207, 0, 0, 0};
        tbl[12] = '{4'b0110, 0, 3'd1, 2, 324, 331, 176, 191, 1, 0, 0};

        #1 reset = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("reset_hs", hor_start, 316);
        chk("reset_he", hor_end, 323);
        chk("reset_vs", ver_start, 192);
        chk("reset_ve", ver_end, 207);
        chk("reset_pulses", {moved, wrap_h, wrap_v}, 0);

        for (int i = 0; i < 13; i++) begin
            pulse(tbl[i].mv, tbl[i].rc, tbl[i].mg, tbl[i].hold, nm, wh, wv);
            chk($sformatf("vec%0d_hs", i), hor_start, tbl[i].hs);
            chk($sformatf("vec%0d_he", i), hor_end, tbl[i].he);
            chk($sformatf("vec%0d_vs", i), ver_start, tbl[i].vs);
            chk($sformatf("vec%0d_ve", i), ver_end, tbl[i].ve);
            chk($sformatf("vec%0d_moves", i), nm, tbl[i].nmv);
            chk($sformatf("vec%0d_wrap_h", i), wh, tbl[i].wh);
            chk($sformatf("vec%0d_wrap_v", i), wv, tbl[i].wv);
        end

        // Horizontal walk to the left edge and wrap, then right-edge wrap.
        pulse(4'b0000, 1, 3'd1, 1, nm, wh, wv);
        for (int i = 0; i < 40; i++) begin
            pulse(4'b1000, 0, 3'd1, 2, nm, wh, wv);
            if (i == 38) chk("left39_hs", hor_start, 4);
        end
        chk("left40_hs", hor_start, 632);
        chk("left40_he", hor_end, 639);
        chk("left40_wrap_h", wh, 1);
        pulse(4'b0100, 0, 3'd1, 2, nm, wh, wv);
        chk("rwrap_hs", hor_start, 0);
        chk("rwrap_he", hor_end, 7);
        chk("rwrap_wrap_h", wh, 1);

        // Vertical walk to the top edge and wrap, then opposing horizontal pair.
        pulse(4'b0000, 1, 3'd1, 1, nm, wh, wv);
        for (int i = 0; i < 13; i++) begin
            pulse(4'b0010, 0, 3'd1, 2, nm, wh, wv);
            if (i == 11) chk("up12_vs", ver_start, 0);
        end
        chk("up13_vs", ver_start, 384);
        chk("up13_ve", ver_end, 399);
        chk("up13_wrap_v", wv, 1);
        pulse(4'b1100, 0, 3'd1, 2, nm, wh, wv);
        chk("lr_moves", nm, 0);
        chk("lr_hs", hor_start, 316);

        // Auto-repeat timing on a 12-cycle hold.
        pulse(4'b0000, 1, 3'd1, 1, nm, wh, wv);
        @(negedge clk);
        move_req = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (moved) offs.push_back(i);
            if (i == 11) move_req = 4'b0;
        end
        chk("rep_count", offs.size(), 5);
        for (int j = 0; j < 5; j++)
            if (j < offs.size()) chk($sformatf("rep_off%0d", j), offs[j] - offs[0], exp_off[j]);
        chk("rep_hs", hor_start, 356);

        // Reset while a button is held.
        @(negedge clk);
        move_req = 4'b0100;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid_hs", hor_start, 316);
        chk("rst_mid_he", hor_end, 323);
        chk("rst_mid_vs", ver_start, 192);
        chk("rst_mid_moved", moved, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        nm = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (moved) nm++;
            if (i == 2) move_req = 4'b0;
        end
        chk("rst_fresh_moves", nm, 1);
        chk("rst_fresh_hs", hor_start, 324);

        // Randomised run, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) move_req = 4'($urandom_range(0, 15));
            recenter = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 99) == 0) mag = 3'($urandom_range(0, 7));
            reset = ($urandom_range(0, 799) == 0);
        end
        @(negedge clk);
        reset = 1'b0;
        move_req = 4'b0;
        recenter = 1'b0;
        repeat (4) @(negedge clk);
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
